// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu
// Brief    : E-stage multiply/divide unit. Owns the HI/LO registers, runs
//            mult/multu/div/divu for a fixed number of busy cycles, and
//            handles mthi/mtlo as single-edge writes. Optional abort input
//            is compiled in with `define MDU_CANCEL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [2:0] c_op_mult  = 3'd0;
  localparam logic [2:0] c_op_multu = 3'd1;
  localparam logic [2:0] c_op_div   = 3'd2;
  localparam logic [2:0] c_op_divu  = 3'd3;
  localparam logic [2:0] c_op_mthi  = 3'd4;
  localparam logic [2:0] c_op_mtlo  = 3'd5;

  localparam logic [4:0] c_mult_n = 5'(MULT_CYCLES);
  localparam logic [4:0] c_div_n  = 5'(DIV_CYCLES);

  logic        r_busy;
  logic [4:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_is_div;
  logic        r_is_signed;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_cancel;
  logic [63:0] w_prod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div0;

`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  // Result is derived from the latched operands and only committed at completion.
  always_comb begin
    w_prod = 64'd0;
    if (r_is_signed)
      w_prod = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    else
      w_prod = {32'd0, r_a} * {32'd0, r_b};
  end

  // Signed divide via magnitudes: quotient sign = sign(a)^sign(b), remainder
  // takes the dividend's sign. 0x80000000 / -1 yields 0x80000000 rem 0.
  always_comb begin
    w_neg_a  = r_is_signed & r_a[31];
    w_neg_b  = r_is_signed & r_b[31];
    w_mag_a  = w_neg_a ? (32'd0 - r_a) : r_a;
    w_mag_b  = w_neg_b ? (32'd0 - r_b) : r_b;
    w_q_u    = 32'd0;
    w_r_u    = 32'd0;
    if (w_mag_b != 32'd0) begin
      w_q_u = w_mag_a / w_mag_b;
      w_r_u = w_mag_a % w_mag_b;
    end
    w_div0   = r_is_div & (r_b == 32'd0);
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (r_is_div) begin
      w_res_lo = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_u) : w_q_u;
      w_res_hi = w_neg_a ? (32'd0 - w_r_u) : w_r_u;
    end
  end

  // Operation sequencing and HI/LO architectural state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy      <= 1'b0;
      r_cnt       <= 5'd0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_is_div    <= 1'b0;
      r_is_signed <= 1'b0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
    end else if (r_busy) begin
      if (w_cancel) begin
        r_busy <= 1'b0;
        r_cnt  <= 5'd0;
      end else if (r_cnt == 5'd1) begin
        r_busy <= 1'b0;
        r_cnt  <= 5'd0;
        if (!w_div0) begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end else begin
        r_cnt <= r_cnt - 5'd1;
      end
    end else if (start && !w_cancel) begin
      case (mdu_op)
        c_op_mult, c_op_multu, c_op_div, c_op_divu: begin
          r_a         <= A;
          r_b         <= B;
          r_is_div    <= mdu_op[1];
          r_is_signed <= ~mdu_op[0];
          r_cnt       <= mdu_op[1] ? c_div_n : c_mult_n;
          r_busy      <= 1'b1;
        end
        c_op_mthi: r_hi <= A;
        c_op_mtlo: r_lo <= A;
        default: ;
      endcase
    end
  end

  assign busy    = r_busy;
  assign hi_out  = r_hi;
  assign lo_out  = r_lo;
  assign rd_data = rd_sel ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mdu
// Brief    : Directed self-checking bench for e_mdu (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        rd_sel;
  logic        cancel;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks   = 0;
  int failures = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdu_op  (mdu_op),
    .A       (A),
    .B       (B),
    .rd_sel  (rd_sel),
`ifdef MDU_CANCEL_EN
    .cancel  (cancel),
`endif
    .busy    (busy),
    .rd_data (rd_data),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a single-edge op (mthi/mtlo/reserved); returns at the next negedge.
  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    start = 1'b1; mdu_op = op; A = a; B = 32'd0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue a mult/div and count the negedges that see busy high.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n, output bit moved);
    logic [31:0] h0, l0;
    h0 = hi_out; l0 = lo_out;
    start = 1'b1; mdu_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    n = 0; moved = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (hi_out !== h0 || lo_out !== l0) moved = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi_out); end
    checks++; if (lo_out !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo_out); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    mt(3'd4, 32'h1234);
    mt(3'd5, 32'h5678);
    start = 1'b1; mdu_op = 3'd0; A = 32'd7; B = 32'd9;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b exp=1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", busy); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL async_hi got=%h exp=00000000", hi_out); end
    checks++; if (lo_out !== 32'd0) begin failures++; $display("FAIL async_lo got=%h exp=00000000", lo_out); end
    @(negedge clk); reset = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL postrst_busy got=%b exp=0", busy); end
    checks++; if (lo_out !== 32'd0) begin failures++; $display("FAIL postrst_lo got=%h exp=00000000", lo_out); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL postrst_hi got=%h exp=00000000", hi_out); end
  endtask

  task automatic test_mult();
    int n; bit moved;
    do_op(3'd0, 32'hFFFFFFFD, 32'd5, n, moved);
    checks++; if (n != 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
    checks++; if (moved) begin failures++; $display("FAIL mult_early_write got=1 exp=0"); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_lo got=%h exp=fffffff1", lo_out); end
    do_op(3'd1, 32'hFFFFFFFD, 32'd5, n, moved);
    checks++; if (n != 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
    checks++; if (hi_out !== 32'h00000004) begin failures++; $display("FAIL multu_hi got=%h exp=00000004", hi_out); end
    checks++; if (lo_out !== 32'hFFFFFFF1) begin failures++; $display("FAIL multu_lo got=%h exp=fffffff1", lo_out); end
    rd_sel = 1'b0; #1;
    checks++; if (rd_data !== 32'hFFFFFFF1) begin failures++; $display("FAIL rd_lo got=%h exp=fffffff1", rd_data); end
    rd_sel = 1'b1; #1;
    checks++; if (rd_data !== 32'h00000004) begin failures++; $display("FAIL rd_hi got=%h exp=00000004", rd_data); end
    rd_sel = 1'b0;
  endtask

  task automatic test_div();
    int n; bit moved;
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, n, moved);
    checks++; if (n != 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
    checks++; if (moved) begin failures++; $display("FAIL div_early_write got=1 exp=0"); end
    checks++; if (lo_out !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo_out); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi_out); end
    do_op(3'd3, 32'd7, 32'd2, n, moved);
    checks++; if (n != 10) begin failures++; $display("FAIL divu_busy_cycles got=%0d exp=10", n); end
    checks++; if (lo_out !== 32'd3) begin failures++; $display("FAIL divu_lo got=%h exp=00000003", lo_out); end
    checks++; if (hi_out !== 32'd1) begin failures++; $display("FAIL divu_hi got=%h exp=00000001", hi_out); end
  endtask

  task automatic test_div_zero();
    int n; bit moved;
    mt(3'd4, 32'h11111111);
    mt(3'd5, 32'h22222222);
    checks++; if (hi_out !== 32'h11111111) begin failures++; $display("FAIL mthi got=%h exp=11111111", hi_out); end
    checks++; if (lo_out !== 32'h22222222) begin failures++; $display("FAIL mtlo got=%h exp=22222222", lo_out); end
    do_op(3'd2, 32'd9, 32'd0, n, moved);
    checks++; if (n != 10) begin failures++; $display("FAIL div0_busy_cycles got=%0d exp=10", n); end
    checks++; if (hi_out !== 32'h11111111) begin failures++; $display("FAIL div0_hi got=%h exp=11111111", hi_out); end
    checks++; if (lo_out !== 32'h22222222) begin failures++; $display("FAIL div0_lo got=%h exp=22222222", lo_out); end
  endtask

  task automatic test_ignore_busy();
    int guard;
    start = 1'b1; mdu_op = 3'd0; A = 32'd3; B = 32'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd5; A = 32'h0000DEAD;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_timeout busy=%b exp=0", busy); end
    checks++; if (lo_out !== 32'd12) begin failures++; $display("FAIL ign_lo got=%h exp=0000000c", lo_out); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL ign_hi got=%h exp=00000000", hi_out); end
    mt(3'd4, 32'h0000BEEF);
    checks++; if (hi_out !== 32'h0000BEEF) begin failures++; $display("FAIL b2b_mthi got=%h exp=0000beef", hi_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_mthi_busy got=%b exp=0", busy); end
    checks++; if (lo_out !== 32'd12) begin failures++; $display("FAIL b2b_mthi_lo got=%h exp=0000000c", lo_out); end
  endtask

  task automatic test_reserved();
    mt(3'd6, 32'h55555555);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rsv6_busy got=%b exp=0", busy); end
    mt(3'd7, 32'h66666666);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rsv7_busy got=%b exp=0", busy); end
    checks++; if (hi_out !== 32'h0000BEEF) begin failures++; $display("FAIL rsv_hi got=%h exp=0000beef", hi_out); end
    checks++; if (lo_out !== 32'd12) begin failures++; $display("FAIL rsv_lo got=%h exp=0000000c", lo_out); end
  endtask

  task automatic test_back_to_back();
    int n; bit moved;
    do_op(3'd1, 32'd2, 32'd3, n, moved);
    checks++; if (n != 5) begin failures++; $display("FAIL b2b1_cycles got=%0d exp=5", n); end
    checks++; if (lo_out !== 32'd6 || hi_out !== 32'd0) begin failures++; $display("FAIL b2b1_result got=%h_%h exp=00000000_00000006", hi_out, lo_out); end
    do_op(3'd3, 32'd20, 32'd6, n, moved);
    checks++; if (n != 10) begin failures++; $display("FAIL b2b2_cycles got=%0d exp=10", n); end
    checks++; if (lo_out !== 32'd3) begin failures++; $display("FAIL b2b2_lo got=%h exp=00000003", lo_out); end
    rd_sel = 1'b1; #1;
    checks++; if (rd_data !== 32'd2) begin failures++; $display("FAIL b2b2_rd_hi got=%h exp=00000002", rd_data); end
    rd_sel = 1'b0;
  endtask

`ifdef MDU_CANCEL_EN
  task automatic test_cancel();
    mt(3'd4, 32'hAAAAAAAA);
    mt(3'd5, 32'hBBBBBBBB);
    start = 1'b1; mdu_op = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cancel_pre_busy got=%b exp=1", busy); end
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    repeat (12) @(negedge clk);
    checks++; if (hi_out !== 32'hAAAAAAAA) begin failures++; $display("FAIL cancel_hi got=%h exp=aaaaaaaa", hi_out); end
    checks++; if (lo_out !== 32'hBBBBBBBB) begin failures++; $display("FAIL cancel_lo got=%h exp=bbbbbbbb", lo_out); end
    cancel = 1'b1;
    mt(3'd4, 32'h00000001);
    cancel = 1'b0;
    checks++; if (hi_out !== 32'hAAAAAAAA) begin failures++; $display("FAIL cancel_mthi got=%h exp=aaaaaaaa", hi_out); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; A = 32'd0; B = 32'd0;
    rd_sel = 1'b0; cancel = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_busy();
    test_reserved();
    test_back_to_back();
`ifdef MDU_CANCEL_EN
    test_cancel();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Multiply/divide unit for the E (execute) pipeline stage. It runs in parallel with the ALU and owns the HI/LO architectural registers. Its HI/LO read value is muxed into the E-stage result that feeds the M-stage pipeline register (AO path, for mfhi/mflo). Its busy/start status goes to the hazard unit, which stalls the F/D stages while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..31)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..31)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  issue strobe for the op on mdu_op; sampled at the rising clk edge
mdu_op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6,7 reserved (no effect)
A  input  32  rs operand (forwarded value)
B  input  32  rt operand (forwarded value)
rd_sel  input  1  0 = read LO, 1 = read HI
busy  output  1  registered; high while a mult/div is in flight
rd_data  output  32  combinational HI or LO, selected by rd_sel
hi_out  output  32  registered HI
lo_out  output  32  registered LO

Behaviour:
- Reset (reset=0, asynchronous): busy=0, HI=0, LO=0, counter=0, pending result cleared. An in-flight op is discarded.
- Accept rule: start is honoured only when busy=0. A start while busy=1 is ignored; the hazard unit never issues one.
- mult/multu/div/divu accepted at edge T0:
  - Latch A, B and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 after T0.
- Each subsequent edge decrements the counter. At edge T0+N (N = the loaded count):
  - HI/LO take the result.
  - busy returns to 0.
  - busy is therefore high for exactly N cycles. With N=1, busy pulses for one cycle.
- Result computation: the result may be computed at T0 and held, or iteratively. Only visible timing matters: HI/LO change only at T0+N.
- mult: signed 32x32->64, HI=[63:32], LO=[31:0]. multu: unsigned.
- div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend. divu: unsigned.
- Divide by zero (B=0 at accept): the op runs the full DIV_CYCLES with busy asserted. HI/LO are left unchanged at completion.
- mthi/mtlo accepted (busy=0):
  - HI (or LO) <= A at that same edge, with no busy.
  - The other register is unchanged.
- Stall contract: the hazard unit stalls on (start & op is mult/div) | busy, and on mfhi/mflo/mthi/mtlo in D while that term is true.
- rd_data reflects HI/LO as registered. No bypass of an in-flight result.
- Reserved ops with start=1: no state change, busy stays 0.
- Back-to-back: a new start in the cycle after busy falls is accepted normally.

Optional Feature:
Macro MDU_CANCEL_EN.
- Defined: adds input port cancel (1 bit, placed after rd_sel).
  - cancel=1 at an edge aborts any in-flight op: busy->0, HI/LO unchanged.
  - cancel=1 also suppresses a start (including mthi/mtlo) sampled at the same edge.
  - Used for exception flush in the next project phase.
- Undefined: port absent; ops always run to completion.

Test Plan:
- Reset: hold reset=0 mid-mult (busy=1) -> busy=0 immediately (asynchronous), hi_out=lo_out=0, and no later HI/LO update.
- mult A=0xFFFFFFFD, B=5 -> busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. Repeat with multu -> HI=0x00000004, LO=0xFFFFFFF1.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- div by zero: preload HI=0x11111111, LO=0x22222222 via mthi/mtlo, then div A=9, B=0 -> busy for 10 cycles, HI/LO unchanged.
- Start ignored while busy: mult 3x4, then start mtlo A=0xDEAD in the 2nd busy cycle -> LO=12, HI=0 at completion, no 0xDEAD write. Then mthi A=0xBEEF right after busy falls -> HI=0xBEEF next cycle, busy stays 0.
- (MDU_CANCEL_EN) divu 100/7 with cancel pulsed in busy cycle 4 -> busy=0 next cycle, HI/LO keep their prior values.
